// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmit path.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for one UART frame, LSB first.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstN,
  input  logic                  i_load,
  input  logic                  i_shiftEn,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_serBit,
  output logic                  o_serDone
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_count;

  // The counter wraps explicitly so a power-of-two width never needs an extra bit.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_count <= '0;
    end else if (i_shiftEn) begin
      r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
      r_count <= (r_count == LAST_IDX) ? '0 : r_count + 1'b1;
    end
  end

  assign o_serBit  = r_shift[0];
  assign o_serDone = i_shiftEn && (r_count == LAST_IDX);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame controller: start, LSB-first data, optional parity, stop.
// One CLK cycle per bit; TX_OUT and Busy come straight from flops.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  Busy
);

  txState_e r_state;
  txState_e w_nextState;
  logic     r_parEn;
  logic     r_dataLast;
  logic     r_txOut;
  logic     r_busy;
  logic     w_txNext;
  logic     w_load;
  logic     w_shiftEn;
  logic     w_serBit;
  logic     w_serDone;

  assign w_load = (r_state == IDLE) && Data_Valid;

  // Shift on the edge leaving START and on every DATA edge except the one leaving the last bit.
  assign w_shiftEn = (r_state == START) || ((r_state == DATA) && !r_dataLast);

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .i_clk     (CLK),
    .i_rstN    (RST),
    .i_load    (w_load),
    .i_shiftEn (w_shiftEn),
    .i_data    (P_DATA),
    .o_serBit  (w_serBit),
    .o_serDone (w_serDone)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_txOut    <= IDLE_LEVEL;
      r_busy     <= 1'b0;
      r_parEn    <= 1'b0;
      r_dataLast <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_txOut    <= w_txNext;
      r_busy     <= (w_nextState != IDLE);
      r_dataLast <= w_serDone;
      if (w_load) begin
        r_parEn <= PAR_EN;
      end
    end
  end

  // The line level is decoded from the next state so each bit is registered on the edge that enters it.
  always_comb begin
    w_nextState = IDLE;
    w_txNext    = IDLE_LEVEL;

    case (r_state)
      IDLE:    w_nextState = Data_Valid ? START : IDLE;
      START:   w_nextState = DATA;
      DATA: begin
        if (r_dataLast) begin
          w_nextState = r_parEn ? PARITY : STOP;
        end else begin
          w_nextState = DATA;
        end
      end
      PARITY:  w_nextState = STOP;
      STOP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase

    case (w_nextState)
      IDLE:    w_txNext = IDLE_LEVEL;
      START:   w_txNext = START_BIT;
      DATA:    w_txNext = w_serBit;
      PARITY:  w_txNext = par_bit;
      STOP:    w_txNext = STOP_BIT;
      default: w_txNext = IDLE_LEVEL;
    endcase
  end

  assign TX_OUT = r_txOut;
  assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: expected {Busy,TX_OUT} per cycle
// is queued when a frame is requested and compared on each falling edge.
module tb_uart_tx_frame_ctrl;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       par_bit;
  logic       TX_OUT;
  logic       Busy;

  int checkCount = 0;
  int errorCount = 0;

  // Each entry is {Busy, TX_OUT} for one bit period.
  logic [1:0] expQ[$];

  uart_tx_frame_ctrl #(
    .DATA_WIDTH(8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .par_bit    (par_bit),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic pushFrame(input logic [7:0] data, input logic parEn, input logic parBit);
    expQ.push_back({1'b1, 1'b0});
    for (int i = 0; i < 8; i++) begin
      expQ.push_back({1'b1, data[i]});
    end
    if (parEn) begin
      expQ.push_back({1'b1, parBit});
    end
    expQ.push_back({1'b1, 1'b1});
  endtask

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++) begin
      expQ.push_back({1'b0, 1'b1});
    end
  endtask

  // Raises Data_Valid for exactly one acceptance edge; leaves the bench in cycle 1 of the frame.
  task automatic applyStimulus(input logic [7:0] data, input logic parEn, input logic parTyp, input int idleAfter);
    logic pb;
    pb = (^data) ^ parTyp;
    @(negedge CLK);
    #1;
    P_DATA     = data;
    PAR_EN     = parEn;
    par_bit    = pb;
    Data_Valid = 1'b1;
    pushFrame(data, parEn, pb);
    pushIdle(idleAfter);
    @(negedge CLK);
    #1;
    Data_Valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    if (expQ.size() > 0) begin
      checkOutput("drain_timeout", expQ.size(), 0);
      expQ.delete();
    end
  endtask

  always @(negedge CLK) begin
    logic [1:0] expVal;
    if (expQ.size() > 0) begin
      expVal = expQ.pop_front();
      checkOutput("busy_tx", {Busy, TX_OUT}, expVal);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST        = 1'b0;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    par_bit    = 1'b0;

    #12;
    checkOutput("reset_tx", TX_OUT, 1'b1);
    checkOutput("reset_busy", Busy, 1'b0);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    pushIdle(2);
    waitDrain(20);

    $display("[TB] reset asserted mid-frame");
    @(negedge CLK);
    #1;
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b0;
    Data_Valid = 1'b1;
    @(negedge CLK);
    #1;
    Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    checkOutput("busy_before_reset", Busy, 1'b1);
    RST = 1'b0;
    #1;
    checkOutput("midreset_tx", TX_OUT, 1'b1);
    checkOutput("midreset_busy", Busy, 1'b0);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    pushIdle(4);
    waitDrain(20);

    $display("[TB] A5 without parity");
    applyStimulus(8'hA5, 1'b0, 1'b0, 2);
    waitDrain(50);

    $display("[TB] A5 with even parity");
    applyStimulus(8'hA5, 1'b1, 1'b0, 2);
    waitDrain(50);

    $display("[TB] A5 with odd parity");
    applyStimulus(8'hA5, 1'b1, 1'b1, 2);
    waitDrain(50);

    $display("[TB] back-to-back frames with Data_Valid held");
    @(negedge CLK);
    #1;
    P_DATA     = 8'h0F;
    PAR_EN     = 1'b0;
    par_bit    = 1'b0;
    Data_Valid = 1'b1;
    pushFrame(8'h0F, 1'b0, 1'b0);
    pushIdle(1);
    pushFrame(8'hF0, 1'b0, 1'b0);
    pushIdle(2);
    repeat (3) @(negedge CLK);
    #1;
    P_DATA = 8'hF0;
    repeat (12) @(negedge CLK);
    #1;
    Data_Valid = 1'b0;
    waitDrain(60);

    $display("[TB] PAR_EN dropped mid-frame");
    applyStimulus(8'h3C, 1'b1, 1'b1, 2);
    repeat (3) @(negedge CLK);
    #1;
    PAR_EN = 1'b0;
    P_DATA = 8'hFF;
    waitDrain(50);

    $display("[TB] Data_Valid pulse during STOP");
    applyStimulus(8'hA5, 1'b0, 1'b0, 4);
    repeat (9) @(negedge CLK);
    #1;
    Data_Valid = 1'b1;
    @(negedge CLK);
    #1;
    Data_Valid = 1'b0;
    waitDrain(50);

    $display("[TB] 5A without parity");
    applyStimulus(8'h5A, 1'b0, 1'b0, 2);
    waitDrain(50);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
